// File: rtl/inst_encoder_if.sv
// Sequencer/decoder side bundle for the SIMD instruction encoder.
// The master drives field sets and issue permission; the slave (encoder)
// returns the issued word, status flags and counters.
interface inst_encoder_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_opcode;
   logic [2:0]       in_data_mode;
   logic             in_imm_flag;
   logic [7:0]       in_imm;
   logic             issue_en;
   logic [15:0]      inst;
   logic             inst_valid;
   logic             illegal;
   logic             full;
   logic             empty;
   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] issued_cnt;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output in_valid, in_opcode, in_data_mode, in_imm_flag, in_imm, issue_en,
      input  in_ready, inst, inst_valid, illegal, full, empty, level,
             issued_cnt, illegal_cnt
   );

   modport slave (
      input  in_valid, in_opcode, in_data_mode, in_imm_flag, in_imm, issue_en,
      output in_ready, inst, inst_valid, illegal, full, empty, level,
             issued_cnt, illegal_cnt
   );
endinterface

// File: rtl/inst_encoder.sv
// Packs sequencer field sets into 16-bit SIMD ALU words
// {opcode, data_mode, imm_flag, imm}, buffers them in a small FIFO and issues
// one word per enabled cycle. Illegal field sets become the canonical NOP so
// program order and slot count are preserved.
module inst_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input logic           clk,
   input logic           rst_n,
   inst_encoder_if.slave bus
);
   localparam int               PTR_W   = $clog2(DEPTH);
   localparam int               LVL_W   = PTR_W + 1;
   localparam logic [15:0]      NOP     = 16'h0100;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [15:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [LVL_W-1:0] r_level;
   logic [15:0]      r_inst;
   logic             r_instValid;
   logic             r_illegal;
   logic [CNT_W-1:0] r_issuedCnt;
   logic [CNT_W-1:0] r_illegalCnt;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_illegalSet;
   logic [15:0]      w_word;

   assign w_full       = (r_level == LVL_W'(DEPTH));
   assign w_empty      = (r_level == '0);
   assign w_push       = bus.in_valid && !w_full;
   // Pop is decided from the pre-edge occupancy, so an entry pushed into an
   // empty FIFO can never be issued on the same edge.
   assign w_pop        = bus.issue_en && !w_empty;
   assign w_illegalSet = (bus.in_opcode > 4'd9) || (bus.in_data_mode > 3'd5);
   assign w_word       = w_illegalSet ? NOP
                       : {bus.in_opcode, bus.in_data_mode, bus.in_imm_flag, bus.in_imm};

   // Storage array; no reset needed because the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_word;
      end
   end

   // Read/write pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Issue register: head entry when enabled and available, NOP when enabled but empty, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inst      <= NOP;
         r_instValid <= 1'b0;
      end else if (bus.issue_en) begin
         if (!w_empty) begin
            r_inst      <= r_mem[r_rdPtr];
            r_instValid <= 1'b1;
         end else begin
            r_inst      <= NOP;
            r_instValid <= 1'b0;
         end
      end else begin
         r_instValid <= 1'b0;
      end
   end

   // Illegal-accept pulse and its saturating counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal    <= 1'b0;
         r_illegalCnt <= '0;
      end else begin
         r_illegal <= w_push && w_illegalSet;
         if (w_push && w_illegalSet && (r_illegalCnt != CNT_MAX)) begin
            r_illegalCnt <= r_illegalCnt + 1'b1;
         end
      end
   end

   // Saturating count of words actually issued with inst_valid set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issuedCnt <= '0;
      end else if (w_pop && (r_issuedCnt != CNT_MAX)) begin
         r_issuedCnt <= r_issuedCnt + 1'b1;
      end
   end

   assign bus.in_ready    = !w_full;
   assign bus.inst        = r_inst;
   assign bus.inst_valid  = r_instValid;
   assign bus.illegal     = r_illegal;
   assign bus.full        = w_full;
   assign bus.empty       = w_empty;
   assign bus.level       = r_level;
   assign bus.issued_cnt  = r_issuedCnt;
   assign bus.illegal_cnt = r_illegalCnt;
endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed scenarios followed by randomized
// traffic, with a queue-based reference model checked every cycle.
// Two instances share the stimulus: one with 8-bit counters, one with 2-bit
// counters to exercise saturation.
module tb_inst_encoder;
   localparam int          DEPTH = 4;
   localparam logic [15:0] NOP   = 16'h0100;

   logic clk;
   logic rst_n;

   logic       inValid;
   logic [3:0] inOpcode;
   logic [2:0] inDataMode;
   logic       inImmFlag;
   logic [7:0] inImm;
   logic       issueEn;

   int checks;
   int errors;

   inst_encoder_if #(.DEPTH(DEPTH), .CNT_W(8)) if1 ();
   inst_encoder_if #(.DEPTH(DEPTH), .CNT_W(2)) if2 ();

   assign if1.in_valid     = inValid;
   assign if1.in_opcode    = inOpcode;
   assign if1.in_data_mode = inDataMode;
   assign if1.in_imm_flag  = inImmFlag;
   assign if1.in_imm       = inImm;
   assign if1.issue_en     = issueEn;
   assign if2.in_valid     = inValid;
   assign if2.in_opcode    = inOpcode;
   assign if2.in_data_mode = inDataMode;
   assign if2.in_imm_flag  = inImmFlag;
   assign if2.in_imm       = inImm;
   assign if2.issue_en     = issueEn;

   inst_encoder #(.DEPTH(DEPTH), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if1));
   inst_encoder #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state: the FIFO is just a queue of packed words.
   logic [15:0] modelQ [$];
   logic [15:0] mInst     = NOP;
   logic        mValid    = 1'b0;
   logic        mIllegal  = 1'b0;
   int          mIssued8  = 0;
   int          mIssued2  = 0;
   int          mIllCnt8  = 0;
   int          mIllCnt2  = 0;
   logic        mPush;
   logic        mBad;
   logic [15:0] mWord;

   // Model advances on every active edge, or clears on reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         modelQ.delete();
         mInst    = NOP;
         mValid   = 1'b0;
         mIllegal = 1'b0;
         mIssued8 = 0;
         mIssued2 = 0;
         mIllCnt8 = 0;
         mIllCnt2 = 0;
      end else begin
         mPush = inValid && (modelQ.size() < DEPTH);
         mBad  = (int'(inOpcode) > 9) || (int'(inDataMode) > 5);
         mWord = mBad ? NOP : {inOpcode, inDataMode, inImmFlag, inImm};
         if (issueEn) begin
            if (modelQ.size() > 0) begin
               mInst    = modelQ.pop_front();
               mValid   = 1'b1;
               mIssued8 = (mIssued8 < 255) ? mIssued8 + 1 : 255;
               mIssued2 = (mIssued2 < 3) ? mIssued2 + 1 : 3;
            end else begin
               mInst  = NOP;
               mValid = 1'b0;
            end
         end else begin
            mValid = 1'b0;
         end
         if (mPush) begin
            modelQ.push_back(mWord);
         end
         mIllegal = mPush && mBad;
         if (mIllegal) begin
            mIllCnt8 = (mIllCnt8 < 255) ? mIllCnt8 + 1 : 255;
            mIllCnt2 = (mIllCnt2 < 3) ? mIllCnt2 + 1 : 3;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare both instances against the model away from the active edge.
   always @(negedge clk) begin
      checkOutput("inst",        32'(if1.inst),        32'(mInst));
      checkOutput("inst_valid",  32'(if1.inst_valid),  32'(mValid));
      checkOutput("illegal",     32'(if1.illegal),     32'(mIllegal));
      checkOutput("level",       32'(if1.level),       32'(modelQ.size()));
      checkOutput("full",        32'(if1.full),        32'(modelQ.size() == DEPTH));
      checkOutput("empty",       32'(if1.empty),       32'(modelQ.size() == 0));
      checkOutput("in_ready",    32'(if1.in_ready),    32'(modelQ.size() < DEPTH));
      checkOutput("issued8",     32'(if1.issued_cnt),  32'(mIssued8));
      checkOutput("illegal8",    32'(if1.illegal_cnt), 32'(mIllCnt8));
      checkOutput("inst2",       32'(if2.inst),        32'(mInst));
      checkOutput("level2",      32'(if2.level),       32'(modelQ.size()));
      checkOutput("issued2",     32'(if2.issued_cnt),  32'(mIssued2));
      checkOutput("illegal2",    32'(if2.illegal_cnt), 32'(mIllCnt2));
   end

   // Drive one cycle of inputs just after a falling edge and wait for the next one.
   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [2:0] mode,
                                input logic flag, input logic [7:0] imm, input logic ie);
      inValid    = v;
      inOpcode   = op;
      inDataMode = mode;
      inImmFlag  = flag;
      inImm      = imm;
      issueEn    = ie;
      @(negedge clk);
   endtask

   logic [15:0] fillWords [4];
   logic [3:0]  rOp;
   logic [2:0]  rMode;
   logic        rFlag;
   logic [7:0]  rImm;
   logic        rValid;
   logic        rIssue;

   // Directed scenarios, then randomized traffic.
   initial begin
      checks     = 0;
      errors     = 0;
      inValid    = 1'b0;
      inOpcode   = 4'h0;
      inDataMode = 3'h0;
      inImmFlag  = 1'b0;
      inImm      = 8'h00;
      issueEn    = 1'b0;
      rst_n      = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset with issue enabled.
      repeat (3) applyStimulus(1'b0, 4'h0, 3'h0, 1'b0, 8'h00, 1'b1);
      checkOutput("idle_inst",   32'(if1.inst),       32'h0100);
      checkOutput("idle_valid",  32'(if1.inst_valid), 32'h0);
      checkOutput("idle_empty",  32'(if1.empty),      32'h1);
      checkOutput("idle_issued", 32'(if1.issued_cnt), 32'h0);

      // One legal word; no same-cycle bypass, visible one edge later.
      applyStimulus(1'b1, 4'h1, 3'd2, 1'b0, 8'h5A, 1'b1);
      checkOutput("lat_valid", 32'(if1.inst_valid), 32'h0);
      checkOutput("lat_level", 32'(if1.level),      32'h1);
      applyStimulus(1'b0, 4'h0, 3'h0, 1'b0, 8'h00, 1'b1);
      checkOutput("legal_inst",   32'(if1.inst),       32'h145A);
      checkOutput("legal_valid",  32'(if1.inst_valid), 32'h1);
      checkOutput("legal_issued", 32'(if1.issued_cnt), 32'h1);

      // Illegal opcode becomes NOP with a one-cycle pulse.
      applyStimulus(1'b1, 4'hC, 3'd1, 1'b0, 8'hFF, 1'b1);
      checkOutput("ill_pulse", 32'(if1.illegal),     32'h1);
      checkOutput("ill_cnt",   32'(if1.illegal_cnt), 32'h1);
      applyStimulus(1'b0, 4'h0, 3'h0, 1'b0, 8'h00, 1'b1);
      checkOutput("ill_pulse_end", 32'(if1.illegal),    32'h0);
      checkOutput("ill_inst",      32'(if1.inst),       32'h0100);
      checkOutput("ill_valid",     32'(if1.inst_valid), 32'h1);

      // Fill to full with issue disabled; fifth push must be ignored.
      fillWords[0] = 16'h2110;
      fillWords[1] = 16'h3320;
      fillWords[2] = 16'h4530;
      fillWords[3] = 16'h5740;
      applyStimulus(1'b1, 4'h2, 3'd0, 1'b1, 8'h10, 1'b0);
      applyStimulus(1'b1, 4'h3, 3'd1, 1'b1, 8'h20, 1'b0);
      applyStimulus(1'b1, 4'h4, 3'd2, 1'b1, 8'h30, 1'b0);
      applyStimulus(1'b1, 4'h5, 3'd3, 1'b1, 8'h40, 1'b0);
      checkOutput("fill_full",  32'(if1.full),     32'h1);
      checkOutput("fill_ready", 32'(if1.in_ready), 32'h0);
      checkOutput("fill_level", 32'(if1.level),    32'h4);
      applyStimulus(1'b1, 4'h6, 3'd4, 1'b0, 8'h77, 1'b0);
      checkOutput("over_level", 32'(if1.level), 32'h4);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'h0, 3'h0, 1'b0, 8'h00, 1'b1);
         checkOutput("drain_inst",  32'(if1.inst),       32'(fillWords[i]));
         checkOutput("drain_valid", 32'(if1.inst_valid), 32'h1);
         if (i == 0) checkOutput("drain_ready", 32'(if1.in_ready), 32'h1);
      end
      applyStimulus(1'b0, 4'h0, 3'h0, 1'b0, 8'h00, 1'b1);
      checkOutput("drained_inst",  32'(if1.inst),       32'h0100);
      checkOutput("drained_valid", 32'(if1.inst_valid), 32'h0);
      checkOutput("sat_issued8",   32'(if1.issued_cnt), 32'd6);
      checkOutput("sat_issued2",   32'(if2.issued_cnt), 32'd3);

      // Asynchronous reset with three entries buffered.
      applyStimulus(1'b1, 4'h7, 3'd5, 1'b0, 8'h01, 1'b0);
      applyStimulus(1'b1, 4'h8, 3'd4, 1'b1, 8'h02, 1'b0);
      applyStimulus(1'b1, 4'h9, 3'd3, 1'b0, 8'h03, 1'b0);
      checkOutput("pre_rst_level", 32'(if1.level), 32'h3);
      inValid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_level",  32'(if1.level),      32'h0);
      checkOutput("rst_empty",  32'(if1.empty),      32'h1);
      checkOutput("rst_inst",   32'(if1.inst),       32'h0100);
      checkOutput("rst_issued", 32'(if1.issued_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 4'h0, 3'h0, 1'b0, 8'h00, 1'b1);
         checkOutput("post_rst_valid", 32'(if1.inst_valid), 32'h0);
      end

      // Randomized traffic with one mid-run reset pulse.
      for (int i = 0; i < 800; i++) begin
         rValid = ($urandom_range(0, 99) < 70);
         rIssue = ($urandom_range(0, 99) < 55);
         rOp    = 4'($urandom_range(0, 15));
         rMode  = 3'($urandom_range(0, 7));
         rFlag  = 1'($urandom_range(0, 1));
         rImm   = 8'($urandom_range(0, 255));
         if (i == 400) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         applyStimulus(rValid, rOp, rMode, rFlag, rImm, rIssue);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
